// File: rtl/md_pkg.sv
// Shared constants for the signed multiply/divide sequencer: function codes,
// FSM state encodings, operand width and iteration count.
package md_pkg;

  localparam int WIDTH = 32;
  localparam int ITER  = 32;

  localparam logic [4:0] FS_MULT = 5'h1E;
  localparam logic [4:0] FS_DIV  = 5'h1F;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_MUL   = 2'd1;
  localparam logic [1:0] ST_DIV   = 2'd2;
  localparam logic [1:0] ST_FIXUP = 2'd3;

  // Magnitude of a two's-complement value; the most negative value maps to
  // itself, which is the correct unsigned magnitude.
  function automatic logic [WIDTH-1:0] abs_val(input logic [WIDTH-1:0] x);
    return x[WIDTH-1] ? -x : x;
  endfunction

endpackage

// File: rtl/md_step.sv
// One 33-bit add/subtract iteration step, shared by the shift-add multiply
// and the restoring shift-subtract divide.
module md_step
  import md_pkg::*;
(
  input  logic [WIDTH:0] a,
  input  logic [WIDTH:0] b,
  input  logic           sub,
  output logic [WIDTH:0] y
);

  assign y = sub ? (a - b) : (a + b);

endmodule

// File: rtl/md_sequencer.sv
// Multi-cycle signed multiply/divide: magnitudes are iterated for 32 cycles,
// then a single FIXUP cycle applies signs and registers results and flags.
module md_sequencer
  import md_pkg::*;
#(
  parameter int WIDTH = md_pkg::WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [4:0]       FS,
  input  logic [WIDTH-1:0] S,
  input  logic [WIDTH-1:0] T,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Y_hi,
  output logic [WIDTH-1:0] Y_lo,
  output logic             N,
  output logic             Z,
  output logic             V,
  output logic             C
);

  logic [1:0]       state_q, state_d;
  logic [5:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0] hi_q, hi_d;      // product high / partial remainder
  logic [WIDTH-1:0] lo_q, lo_d;      // multiplier / dividend-then-quotient
  logic [WIDTH-1:0] opnd_q, opnd_d;  // |S| for multiply, |T| for divide
  logic             op_div_q, op_div_d;
  logic             neg_q, neg_d;    // product or quotient sign
  logic             rneg_q, rneg_d;  // remainder sign (dividend's sign)
  logic             dz_q, dz_d;
  logic             ovf_q, ovf_d;
  logic [WIDTH-1:0] y_hi_q, y_hi_d, y_lo_q, y_lo_d;
  logic [3:0]       flags_q, flags_d;  // {N, Z, V, C}
  logic             done_q, done_d;

  logic [WIDTH:0]   step_a, step_b, step_y, sum;
  logic             step_sub, is_div;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0] quo, rem;

  assign step_a   = (state_q == ST_DIV) ? {hi_q, lo_q[WIDTH-1]} : {1'b0, hi_q};
  assign step_b   = {1'b0, opnd_q};
  assign step_sub = (state_q == ST_DIV);

  md_step u_step (
    .a   (step_a),
    .b   (step_b),
    .sub (step_sub),
    .y   (step_y)
  );

  always_comb begin
    // NOTE: every _d and temporary gets a default first, so no path through
    // the case statement can infer a latch.
    state_d  = state_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    opnd_d   = opnd_q;
    op_div_d = op_div_q;
    neg_d    = neg_q;
    rneg_d   = rneg_q;
    dz_d     = dz_q;
    ovf_d    = ovf_q;
    y_hi_d   = y_hi_q;
    y_lo_d   = y_lo_q;
    flags_d  = flags_q;
    done_d   = 1'b0;
    is_div   = (FS == FS_DIV);
    sum      = '0;
    prod     = '0;
    quo      = '0;
    rem      = '0;

    case (state_q)
      ST_IDLE: begin
        if (start && (FS == FS_MULT || FS == FS_DIV)) begin
          op_div_d = is_div;
          cnt_d    = '0;
          hi_d     = '0;
          neg_d    = S[WIDTH-1] ^ T[WIDTH-1];
          rneg_d   = S[WIDTH-1];
          dz_d     = is_div && (T == '0);
          ovf_d    = is_div && (S == {1'b1, {(WIDTH-1){1'b0}}}) && (T == '1);
          lo_d     = is_div ? abs_val(S) : abs_val(T);
          opnd_d   = is_div ? abs_val(T) : abs_val(S);
          if (!is_div)        state_d = ST_MUL;
          else if (T == '0)   state_d = ST_FIXUP;
          else                state_d = ST_DIV;
        end
      end
      ST_MUL: begin
        sum   = lo_q[0] ? step_y : {1'b0, hi_q};
        hi_d  = sum[WIDTH:1];
        lo_d  = {sum[0], lo_q[WIDTH-1:1]};
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == 6'(ITER - 1)) state_d = ST_FIXUP;
      end
      ST_DIV: begin
        // A clear borrow bit means the trial subtraction fits: keep it.
        hi_d  = step_y[WIDTH] ? step_a[WIDTH-1:0] : step_y[WIDTH-1:0];
        lo_d  = {lo_q[WIDTH-2:0], ~step_y[WIDTH]};
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == 6'(ITER - 1)) state_d = ST_FIXUP;
      end
      default: begin
        done_d  = 1'b1;
        state_d = ST_IDLE;
        if (dz_q) begin
          flags_d = 4'b0010;
        end else if (op_div_q) begin
          quo     = neg_q  ? -lo_q : lo_q;
          rem     = rneg_q ? -hi_q : hi_q;
          y_lo_d  = quo;
          y_hi_d  = rem;
          flags_d = {quo[WIDTH-1], (quo == '0), ovf_q, 1'b0};
        end else begin
          prod    = neg_q ? -{hi_q, lo_q} : {hi_q, lo_q};
          y_hi_d  = prod[2*WIDTH-1:WIDTH];
          y_lo_d  = prod[WIDTH-1:0];
          flags_d = {prod[2*WIDTH-1], (prod == '0), 2'b00};
        end
      end
    endcase
  end

  // NOTE: all state updates use non-blocking assignments so every flop samples
  // the pre-edge values, regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      opnd_q   <= '0;
      op_div_q <= 1'b0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      dz_q     <= 1'b0;
      ovf_q    <= 1'b0;
      y_hi_q   <= '0;
      y_lo_q   <= '0;
      flags_q  <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      opnd_q   <= opnd_d;
      op_div_q <= op_div_d;
      neg_q    <= neg_d;
      rneg_q   <= rneg_d;
      dz_q     <= dz_d;
      ovf_q    <= ovf_d;
      y_hi_q   <= y_hi_d;
      y_lo_q   <= y_lo_d;
      flags_q  <= flags_d;
      done_q   <= done_d;
    end
  end

  assign busy         = (state_q != ST_IDLE);
  assign done         = done_q;
  assign Y_hi         = y_hi_q;
  assign Y_lo         = y_lo_q;
  assign {N, Z, V, C} = flags_q;

endmodule

// File: tb/tb_md_sequencer.sv
// Self-checking bench for md_sequencer: a cycle-level reference model built on
// native signed arithmetic, checked every cycle, plus literal spot checks.
module tb_md_sequencer;

  localparam logic [4:0] FS_MULT = 5'h1E;
  localparam logic [4:0] FS_DIV  = 5'h1F;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start;
  logic [4:0]  FS;
  logic [31:0] S, T;
  logic        busy, done, N, Z, V, C;
  logic [31:0] Y_hi, Y_lo;

  int n_checks = 0;
  int n_errors = 0;
  bit cmp_en = 1'b0;

  md_sequencer #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .FS(FS), .S(S), .T(T),
    .busy(busy), .done(done), .Y_hi(Y_hi), .Y_lo(Y_lo),
    .N(N), .Z(Z), .V(V), .C(C)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
    logic [3:0]  nzvc;
    logic        dz;
  } res_t;

  function automatic res_t predict(input logic [4:0] fs, input logic [31:0] s, input logic [31:0] t);
    res_t   r;
    longint p;
    int     si, ti, q, m;
    r = '0;
    if (fs == FS_MULT) begin
      p      = longint'($signed(s)) * longint'($signed(t));
      r.hi   = p[63:32];
      r.lo   = p[31:0];
      r.nzvc = {p[63], (p == 0), 2'b00};
    end else if (t == 32'd0) begin
      r.dz   = 1'b1;
      r.nzvc = 4'b0010;
    end else if (s == 32'h8000_0000 && t == 32'hFFFF_FFFF) begin
      r.lo   = 32'h8000_0000;
      r.hi   = 32'd0;
      r.nzvc = 4'b1010;
    end else begin
      si     = s;
      ti     = t;
      q      = si / ti;
      m      = si % ti;
      r.lo   = q;
      r.hi   = m;
      r.nzvc = {r.lo[31], (q == 0), 2'b00};
    end
    return r;
  endfunction

  int          m_rem;
  logic        m_done;
  logic [31:0] m_hi, m_lo;
  logic [3:0]  m_f;
  res_t        m_pend;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_rem  <= 0;
      m_done <= 1'b0;
      m_hi   <= '0;
      m_lo   <= '0;
      m_f    <= '0;
      m_pend <= '0;
    end else begin
      m_done <= 1'b0;
      if (m_rem > 0) begin
        m_rem <= m_rem - 1;
        if (m_rem == 1) begin
          m_done <= 1'b1;
          m_f    <= m_pend.nzvc;
          if (!m_pend.dz) begin
            m_hi <= m_pend.hi;
            m_lo <= m_pend.lo;
          end
        end
      end else if (start && (FS == FS_MULT || FS == FS_DIV)) begin
        m_pend <= predict(FS, S, T);
        m_rem  <= (FS == FS_DIV && T == 32'd0) ? 1 : 33;
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("busy",  busy, (m_rem != 0));
      check("done",  done, m_done);
      check("y_hi",  Y_hi, m_hi);
      check("y_lo",  Y_lo, m_lo);
      check("flags", {N, Z, V, C}, m_f);
    end
  end

  // ---------------- stimulus ----------------
  task automatic do_op(input logic [4:0] fs, input logic [31:0] s, input logic [31:0] t,
                       input int poke, output int lat);
    @(negedge clk);
    start = 1'b1; FS = fs; S = s; T = t;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0;
    while (!done && lat < 100) begin
      FS = 5'($urandom);
      S  = $urandom;
      T  = $urandom;
      if (lat == poke) begin
        start = 1'b1;
        FS    = FS_MULT;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      lat++;
    end
    start = 1'b0;
    if (!done) check("done_timeout", 64'd0, 64'd1);
  endtask

  task automatic try_invalid(input logic [4:0] fs);
    @(negedge clk);
    start = 1'b1; FS = fs; S = $urandom; T = $urandom;
    @(posedge clk); #1;
    start = 1'b0;
    check("invalid_busy", busy, 1'b0);
    check("invalid_done", done, 1'b0);
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 7))
      0:       return 32'd0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'd1;
      4:       return 32'($urandom_range(0, 40)) - 32'd20;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int          lat;
    logic [4:0]  fs;
    logic [31:0] s, t;
    start = 1'b0; FS = '0; S = '0; T = '0;
    repeat (3) @(negedge clk);
    check("rst_busy",  busy, 1'b0);
    check("rst_done",  done, 1'b0);
    check("rst_y",     {Y_hi, Y_lo}, 64'd0);
    check("rst_flags", {N, Z, V, C}, 4'b0000);
    reset  = 1'b1;
    cmp_en = 1'b1;

    do_op(FS_MULT, 32'd7, 32'hFFFF_FFFD, -1, lat);
    check("mul1_lat",   lat, 33);
    check("mul1_hi",    Y_hi, 32'hFFFF_FFFF);
    check("mul1_lo",    Y_lo, 32'hFFFF_FFEB);
    check("mul1_flags", {N, Z, V, C}, 4'b1000);

    do_op(FS_MULT, 32'h8000_0000, 32'h8000_0000, -1, lat);
    check("mul2_hi",    Y_hi, 32'h4000_0000);
    check("mul2_lo",    Y_lo, 32'h0000_0000);
    check("mul2_flags", {N, Z, V, C}, 4'b0000);

    do_op(FS_DIV, 32'd100, 32'hFFFF_FFF9, -1, lat);
    check("div1_lo",    Y_lo, 32'hFFFF_FFF2);
    check("div1_hi",    Y_hi, 32'h0000_0002);
    check("div1_flags", {N, Z, V, C}, 4'b1000);

    do_op(FS_DIV, 32'h8000_0000, 32'hFFFF_FFFF, -1, lat);
    check("div_ovf_lo",    Y_lo, 32'h8000_0000);
    check("div_ovf_hi",    Y_hi, 32'h0000_0000);
    check("div_ovf_flags", {N, Z, V, C}, 4'b1010);

    do_op(FS_DIV, 32'd5, 32'd0, -1, lat);
    check("dz_lat",   lat, 1);
    check("dz_lo",    Y_lo, 32'h8000_0000);
    check("dz_hi",    Y_hi, 32'h0000_0000);
    check("dz_flags", {N, Z, V, C}, 4'b0010);

    try_invalid(5'h02);
    check("invalid_y", {Y_hi, Y_lo}, 64'h0000_0000_8000_0000);

    do_op(FS_DIV, 32'hFFFF_FC18, 32'd33, 10, lat);
    check("div_poke_lat", lat, 33);
    check("div_poke_lo",  Y_lo, 32'hFFFF_FFE2);
    check("div_poke_hi",  Y_hi, 32'hFFFF_FFF6);
    check("div_poke_flags", {N, Z, V, C}, 4'b1000);

    // Abort a multiply mid-flight.
    @(negedge clk);
    start = 1'b1; FS = FS_MULT; S = 32'h1234_5678; T = 32'h9ABC_DEF0;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #2 reset = 1'b0;
    #1;
    check("abort_busy",  busy, 1'b0);
    check("abort_done",  done, 1'b0);
    check("abort_y",     {Y_hi, Y_lo}, 64'd0);
    check("abort_flags", {N, Z, V, C}, 4'b0000);
    repeat (2) @(negedge clk);
    reset = 1'b1;

    do_op(FS_MULT, 32'd3, 32'd4, -1, lat);
    check("post_rst_lat", lat, 33);
    check("post_rst_lo",  Y_lo, 32'd12);
    check("post_rst_hi",  Y_hi, 32'd0);

    for (int i = 0; i < 60; i++) begin
      s = pick_operand();
      t = pick_operand();
      if ($urandom_range(0, 7) == 0) begin
        try_invalid(5'($urandom_range(0, 29)));
      end else begin
        fs = $urandom_range(0, 1) ? FS_DIV : FS_MULT;
        do_op(fs, s, t, ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 30)) : -1, lat);
        check("rand_lat", lat, (fs == FS_DIV && t == 32'd0) ? 1 : 33);
      end
    end

    repeat (3) @(negedge clk);
    cmp_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
